// File: rtl/serial_pattern_generator_if.sv
// Bundles the control inputs and serial outputs of serial_pattern_generator.
// The master side issues transmission requests; the slave side is the generator.
interface serial_pattern_generator_if #(
   parameter int W     = 6,
   parameter int LEN_W = 3,
   parameter int CNT_W = 4,
   parameter int GAP_W = 3
) ();
   logic             start;
   logic [W-1:0]     pattern;
   logic [LEN_W-1:0] len;
   logic [CNT_W-1:0] repeats;
   logic [GAP_W-1:0] gap;
   logic             new_bit;
   logic             bit_valid;
   logic             busy;
   logic             done;

   modport master (
      output start, pattern, len, repeats, gap,
      input  new_bit, bit_valid, busy, done
   );

   modport slave (
      input  start, pattern, len, repeats, gap,
      output new_bit, bit_valid, busy, done
   );
endinterface

// File: rtl/serial_pattern_generator.sv
// Serialises a captured pattern MSB-first, with programmable length, repeat
// count and zero-filled gaps between repeats; all outputs are registered.
module serial_pattern_generator #(
   parameter int W     = 6,
   parameter int LEN_W = 3,
   parameter int CNT_W = 4,
   parameter int GAP_W = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   serial_pattern_generator_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [W-1:0]     pat_reg, pat_next;
   logic [LEN_W-1:0] len_reg, len_next;
   logic [LEN_W-1:0] bit_idx_reg, bit_idx_next;
   logic [CNT_W-1:0] rep_reg, rep_next;
   logic [GAP_W-1:0] gap_len_reg, gap_len_next;
   logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;

   logic new_bit_reg, new_bit_next;
   logic bit_valid_reg, bit_valid_next;
   logic busy_reg, busy_next;
   logic done_reg, done_next;

   logic [LEN_W-1:0] len_eff;
   logic [W-1:0]     sel_hot;

   // Over-long requests are clamped to the physical pattern width.
   assign len_eff = (bus.len > LEN_W'(W)) ? LEN_W'(W) : bus.len;

   // Next-state, counter and output-valid logic.
   always_comb begin
      state_next     = state_reg;
      pat_next       = pat_reg;
      len_next       = len_reg;
      bit_idx_next   = bit_idx_reg;
      rep_next       = rep_reg;
      gap_len_next   = gap_len_reg;
      gap_cnt_next   = gap_cnt_reg;
      bit_valid_next = 1'b0;
      busy_next      = 1'b0;
      done_next      = 1'b0;

      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               if ((len_eff == '0) || (bus.repeats == '0)) begin
                  done_next = 1'b1;
               end else begin
                  state_next     = SEND;
                  pat_next       = bus.pattern;
                  len_next       = len_eff;
                  rep_next       = bus.repeats;
                  gap_len_next   = bus.gap;
                  bit_idx_next   = len_eff - LEN_W'(1);
                  bit_valid_next = 1'b1;
                  busy_next      = 1'b1;
               end
            end
         end

         SEND: begin
            bit_valid_next = 1'b1;
            busy_next      = 1'b1;
            if (bit_idx_reg != '0) begin
               bit_idx_next = bit_idx_reg - LEN_W'(1);
            end else if (rep_reg > CNT_W'(1)) begin
               rep_next = rep_reg - CNT_W'(1);
               if (gap_len_reg != '0) begin
                  state_next   = GAP;
                  gap_cnt_next = gap_len_reg;
               end else begin
                  bit_idx_next = len_reg - LEN_W'(1);
               end
            end else begin
               state_next     = IDLE;
               bit_valid_next = 1'b0;
               busy_next      = 1'b0;
               done_next      = 1'b1;
            end
         end

         GAP: begin
            bit_valid_next = 1'b1;
            busy_next      = 1'b1;
            if (gap_cnt_reg > GAP_W'(1)) begin
               gap_cnt_next = gap_cnt_reg - GAP_W'(1);
            end else begin
               state_next   = SEND;
               bit_idx_next = len_reg - LEN_W'(1);
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // One-hot bit selector avoids any out-of-range pattern index.
   generate
      for (genvar gi = 0; gi < W; gi++) begin : g_sel
         assign sel_hot[gi] = pat_next[gi] & (bit_idx_next == LEN_W'(gi));
      end
   endgenerate

   assign new_bit_next = (state_next == SEND) & (|sel_hot);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         pat_reg       <= '0;
         len_reg       <= '0;
         bit_idx_reg   <= '0;
         rep_reg       <= '0;
         gap_len_reg   <= '0;
         gap_cnt_reg   <= '0;
         new_bit_reg   <= 1'b0;
         bit_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         pat_reg       <= pat_next;
         len_reg       <= len_next;
         bit_idx_reg   <= bit_idx_next;
         rep_reg       <= rep_next;
         gap_len_reg   <= gap_len_next;
         gap_cnt_reg   <= gap_cnt_next;
         new_bit_reg   <= new_bit_next;
         bit_valid_reg <= bit_valid_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
      end
   end

   assign bus.new_bit   = new_bit_reg;
   assign bus.bit_valid = bit_valid_reg;
   assign bus.busy      = busy_reg;
   assign bus.done      = done_reg;

endmodule

// File: tb/tb_serial_pattern_generator.sv
// Scoreboard bench for serial_pattern_generator: directed transmissions push
// hand-written bit strings; a negedge monitor pops and compares them.
module tb_serial_pattern_generator;
   localparam int W     = 6;
   localparam int LEN_W = 3;
   localparam int CNT_W = 4;
   localparam int GAP_W = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   serial_pattern_generator_if #(.W(W), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

   serial_pattern_generator #(.W(W), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic is_done;
      logic val;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   busy_cycles = 0;
   int   det_pulses = 0;
   int   loop_bits = 0;
   logic loop_en = 1'b0;
   logic [5:0] det_sr = '0;
   logic det = 1'b0;

   task automatic check(input bit ok, input string name, input int act, input int req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d required %0d at time %0t", name, act, req, $time);
      end
   endtask

   task automatic push_str(input string s);
      exp_t e;
      for (int i = 0; i < s.len(); i++) begin
         e.is_done = 1'b0;
         e.val     = (s[i] == "1");
         exp_q.push_back(e);
      end
   endtask

   task automatic push_done();
      exp_t e;
      e.is_done = 1'b1;
      e.val     = 1'b0;
      exp_q.push_back(e);
   endtask

   task automatic start_tx(input logic [W-1:0] pat, input logic [LEN_W-1:0] len,
                           input logic [CNT_W-1:0] rep, input logic [GAP_W-1:0] gap);
      @(negedge clk);
      bus.pattern = pat;
      bus.len     = len;
      bus.repeats = rep;
      bus.gap     = gap;
      bus.start   = 1'b1;
      @(negedge clk);
      bus.start   = 1'b0;
      // Scramble inputs after capture: the transmission must not notice.
      bus.pattern = ~pat;
      bus.len     = len ^ 3'b010;
      bus.repeats = rep + 4'd1;
      bus.gap     = gap ^ 3'b001;
   endtask

   task automatic wait_drain(input string name, input int limit);
      int n = 0;
      while ((exp_q.size() != 0 || bus.busy) && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(exp_q.size() == 0, name, exp_q.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   // Loopback "110011" detector with a registered one-cycle match pulse.
   always @(posedge clk) begin
      det_sr <= {det_sr[4:0], bus.new_bit};
      det    <= ({det_sr[4:0], bus.new_bit} == 6'b110011);
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         check(bus.busy == bus.bit_valid, "busy_vs_valid", bus.busy, bus.bit_valid);
         if (!bus.bit_valid)
            check(bus.new_bit == 1'b0, "idle_new_bit", bus.new_bit, 0);
         if (bus.bit_valid || bus.done) begin
            if (exp_q.size() == 0) begin
               check(1'b0, "unexpected_output", bus.done ? 2 : int'(bus.new_bit), -1);
            end else begin
               e = exp_q.pop_front();
               if (e.is_done)
                  check(bus.done && !bus.bit_valid, "done_pulse",
                        {bus.done, bus.bit_valid}, 2);
               else
                  check(bus.bit_valid && !bus.done && bus.new_bit == e.val, "serial_bit",
                        {bus.done, bus.new_bit}, {1'b0, e.val});
            end
         end
         if (bus.busy) busy_cycles++;
         if (loop_en && det) begin
            det_pulses++;
            check(loop_bits > 0 && loop_bits % 6 == 0, "det_position", loop_bits, 6);
         end
         if (loop_en && bus.bit_valid) loop_bits++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1);
   end

   initial begin
      int n;
      rst         = 1'b0;
      bus.start   = 1'b0;
      bus.pattern = '0;
      bus.len     = '0;
      bus.repeats = '0;
      bus.gap     = '0;
      #2;
      check({bus.busy, bus.bit_valid, bus.new_bit, bus.done} == 4'b0000, "reset_outputs",
            {bus.busy, bus.bit_valid, bus.new_bit, bus.done}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Single pattern, busy for exactly the six bit cycles
      push_str("110011"); push_done();
      busy_cycles = 0;
      start_tx(6'b110011, 3'd6, 4'd1, 3'd0);
      wait_drain("single_drain", 40);
      check(busy_cycles == 6, "busy_cycles", busy_cycles, 6);

      // Two repeats with a two-bit gap, none after the last repeat
      push_str("1010001010"); push_done();
      start_tx(6'b001010, 3'd4, 4'd2, 3'd2);
      wait_drain("gap_drain", 40);

      // start held high: ignored while busy, re-accepted in the done cycle
      push_str("101"); push_done(); push_str("101"); push_done();
      @(negedge clk);
      bus.pattern = 6'b000101; bus.len = 3'd3; bus.repeats = 4'd1; bus.gap = 3'd0;
      bus.start = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.done && n < 40);
      check(bus.done == 1'b1, "first_done_seen", bus.done, 1);
      @(negedge clk);
      bus.start = 1'b0;
      wait_drain("b2b_drain", 40);

      // Degenerate starts: len=0, then repeats=0
      push_done();
      start_tx(6'b111111, 3'd0, 4'd3, 3'd1);
      wait_drain("len0_drain", 20);
      push_done();
      start_tx(6'b111111, 3'd4, 4'd0, 3'd0);
      wait_drain("rep0_drain", 20);

      // Length clamp: len=7 sends six bits
      push_str("100001"); push_done();
      start_tx(6'b100001, 3'd7, 4'd1, 3'd0);
      wait_drain("clamp_drain", 40);

      // Asynchronous reset during the third bit
      push_str("110");
      @(negedge clk);
      bus.pattern = 6'b110011; bus.len = 3'd6; bus.repeats = 4'd1; bus.gap = 3'd0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check({bus.busy, bus.bit_valid, bus.new_bit, bus.done} == 4'b0000, "async_reset",
            {bus.busy, bus.bit_valid, bus.new_bit, bus.done}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (8) @(negedge clk);
      check(exp_q.size() == 0, "reset_leftover", exp_q.size(), 0);
      check(busy_cycles >= 0 && bus.busy == 1'b0, "no_resume", bus.busy, 0);
      push_str("110011"); push_done();
      start_tx(6'b110011, 3'd6, 4'd1, 3'd0);
      wait_drain("post_reset_drain", 40);

      // Loopback into the 110011 detector, three back-to-back repeats
      repeat (8) @(negedge clk);
      det_pulses = 0;
      loop_bits  = 0;
      loop_en    = 1'b1;
      push_str("110011110011110011"); push_done();
      start_tx(6'b110011, 3'd6, 4'd3, 3'd0);
      wait_drain("loop_drain", 60);
      check(det_pulses == 3, "det_pulses", det_pulses, 3);
      check(loop_bits == 18, "loop_bits", loop_bits, 18);
      loop_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_pattern_generator.md
Name: serial_pattern_generator

Overview:
- Transmit-side counterpart of the shift-register sequence detectors: serialises a loaded bit pattern MSB-first onto a one-bit stream, one bit per clock.
- Supports a programmable pattern length, repeat count and zero-filled gap between repeats.
- Drives the new_bit input of detector blocks in loopback benches, and acts as a stimulus source for serial links.

Parameters:
- W, 6: maximum pattern width in bits.
- LEN_W, 3: width of the len port; must satisfy 2^LEN_W > W.
- CNT_W, 4: width of the repeats port.
- GAP_W, 3: width of the gap port.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, active-low, asynchronous assert.
- start  in  1  request a transmission; sampled only in IDLE.
- pattern  in  W  bits to send; bit len-1 is sent first, bit 0 last.
- len  in  LEN_W  number of pattern bits per repeat.
- repeats  in  CNT_W  number of pattern repetitions.
- gap  in  GAP_W  number of zero bits inserted between repeats.
- new_bit  out  1  serial data.
- bit_valid  out  1  new_bit carries a transmitted bit this cycle.
- busy  out  1  transmission in progress.
- done  out  1  one-cycle pulse after the last bit.

Behaviour:
- Reset (rst low): all outputs 0 and FSM in IDLE, immediately and asynchronously, including mid-transmission. No transmission resumes after rst rises.
- All outputs are registered.
- FSM states:
  - IDLE: waiting for start.
  - SEND: shifting out pattern bits.
  - GAP: emitting zero-fill bits.
- Start capture:
  - start=1 in IDLE at edge k captures pattern, len, repeats and gap.
  - Input changes after edge k are ignored until the next IDLE.
  - start while busy=1 is ignored; it is not queued.
- Length clamp: len>W is clamped to W at capture.
- Degenerate start: if the effective len=0 or repeats=0, done=1 for the cycle after edge k. busy and bit_valid stay 0, and the FSM stays in IDLE.
- SEND:
  - After edge k: busy=1, bit_valid=1, new_bit=pattern[len-1].
  - Each following edge advances one bit toward bit 0, so each repeat is len consecutive valid cycles.
- End of a repeat:
  - If repeats remain and gap>0: enter GAP for exactly gap cycles with bit_valid=1 and new_bit=0.
  - Otherwise, if repeats remain: go straight back to SEND with pattern[len-1] and no bubble.
- No gap follows the final repeat.
- Total valid cycles per start = len*repeats + gap*(repeats-1). bit_valid is never deasserted between the first and last bit.
- Completion:
  - The cycle after the last bit: busy=0, bit_valid=0, new_bit=0, done=1.
  - done lasts exactly one cycle.
  - start asserted during the done cycle is accepted, because the FSM is already in IDLE. This gives back-to-back transmissions with a one-cycle bubble.
- Idle outputs: new_bit=0 whenever bit_valid=0.
- Counters:
  - The bit index counts down from len-1.
  - The repeat counter counts down from repeats; the gap counter counts down from gap.
  - No counter wraps; all are reloaded only at capture or at a repeat boundary.

Test Plan:
- Single pattern: pattern=6'b110011, len=6, repeats=1, gap=0, start pulse.
  - Expect bit_valid for 6 cycles with new_bit 1,1,0,0,1,1, then the done pulse on cycle 7.
  - busy is high for cycles 1-6 only.
- Repeats with gap: pattern=6'b001010, len=4, repeats=2, gap=2.
  - Expect valid stream 1,0,1,0,0,0,1,0,1,0 (10 cycles), then done.
  - No gap after the last repeat.
- Busy, back-to-back and degenerate starts:
  - start held high throughout the first transmission: second start ignored while busy; a new transmission begins the cycle after done.
  - Separate start with len=0: done next cycle, bit_valid never 1.
- Length clamp: len=7 with W=6, pattern=6'b100001, repeats=1.
  - Expect exactly 6 valid bits, 1,0,0,0,0,1.
- Reset mid-transmission: drop rst during bit 3 of a len=6 send.
  - All outputs go 0 without waiting for a clock edge; no bits appear after rst rises.
  - The next start sends a complete pattern.
- Loopback: connect new_bit to a 6-bit "110011" detector; pattern=6'b110011, len=6, repeats=3, gap=0.
  - The detector asserts exactly 3 one-cycle pulses, each one cycle after the 6th bit of each repeat.
